uart_transmitter: RTL and testbench

//   8N1-style asynchronous serial transmitter on the host link. It accepts one byte per

---
 rtl/uart_transmitter.sv | 107 ++++++++++
 tb/tb_uart_transmitter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// 8N1-style serial transmitter: one byte per tran_data strobe, sent LSB-first on tx.
// All outputs are registered. tx_done pulses in the final cycle of the last stop bit.
module uart_transmitter #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD_RATE   = 115_200,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] transmit_byte,
  input  logic       tran_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int unsigned CntW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] LastCnt    = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] PreLastCnt = CntW'(CLKS_PER_BIT - 2);
  localparam logic [2:0]      LastStop   = 3'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : gen_bad_baud
    $error("uart_transmitter: CLKS_PER_BIT must be at least 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : gen_bad_stop
    $error("uart_transmitter: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q;
  logic [CntW-1:0] baud_cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;

  wire bit_end = (baud_cnt_q == LastCnt);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          baud_cnt_q <= '0;
          bit_idx_q  <= '0;
          if (tran_data) begin
            shift_q <= transmit_byte;
            state_q <= StStart;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
          end
        end
        StStart: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            state_q    <= StData;
            tx         <= shift_q[0];
          end else begin
            baud_cnt_q <= baud_cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= '0;
              state_q   <= StStop;
              tx        <= 1'b1;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              tx        <= shift_q[1];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CntW'(1);
          end
        end
        StStop: begin
          // Raise done one edge early so it is high during the final stop cycle.
          tx_done <= (baud_cnt_q == PreLastCnt) && (bit_idx_q == LastStop);
          if (bit_end) begin
            baud_cnt_q <= '0;
            if (bit_idx_q == LastStop) begin
              bit_idx_q <= '0;
              state_q   <= StIdle;
              tx_busy   <= 1'b0;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: receiver model with scoreboard plus per-scenario timing checks.
module tb_uart_transmitter;

  localparam int CPB = 10;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] transmit_byte, transmit_byte2;
  logic       tran_data, tran_data2;
  logic       tx_busy, tx_done, tx;
  logic       tx_busy2, tx_done2, tx2;

  int checks = 0;
  int passed = 0;
  logic [7:0] sb_q[$];

  always #5 clock = ~clock;

  uart_transmitter #(.CLK_FREQ_HZ(1000), .BAUD_RATE(100), .STOP_BITS(1)) dut (
    .clock(clock), .reset_n(reset_n), .transmit_byte(transmit_byte), .tran_data(tran_data),
    .tx_busy(tx_busy), .tx_done(tx_done), .tx(tx)
  );

  uart_transmitter #(.CLK_FREQ_HZ(1000), .BAUD_RATE(100), .STOP_BITS(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .transmit_byte(transmit_byte2), .tran_data(tran_data2),
    .tx_busy(tx_busy2), .tx_done(tx_done2), .tx(tx2)
  );

  // Receiver model: detects a start bit, samples mid-bit, pops and compares the scoreboard.
  initial begin : rx_model
    logic [7:0] rx_b;
    logic [7:0] exp_b;
    bit         frame_ok;
    bit         aborted;
    int         bitn;
    forever begin
      @(posedge clock); #2;
      if (reset_n === 1'b1 && tx === 1'b0) begin
        rx_b = '0; frame_ok = 1; aborted = 0;
        for (int c = 1; c <= CPB / 2 + 9 * CPB; c++) begin
          @(posedge clock); #2;
          if (reset_n !== 1'b1) begin
            aborted = 1;
            break;
          end
          if (c == CPB / 2) begin
            if (tx !== 1'b0) frame_ok = 0;
          end else if (c > CPB / 2 && (c - CPB / 2) % CPB == 0) begin
            bitn = (c - CPB / 2) / CPB;
            if (bitn <= 8) rx_b[bitn-1] = tx;
            else if (tx !== 1'b1) frame_ok = 0;
          end
        end
        if (!aborted) begin
          checks++;
          if (sb_q.size() == 0) begin
            $display("FAIL rx_unexpected: decoded %h, required no frame", rx_b);
          end else begin
            exp_b = sb_q.pop_front();
            if (rx_b !== exp_b || !frame_ok)
              $display("FAIL rx_byte: got %h framing_ok=%0d, required %h framing_ok=1",
                       rx_b, frame_ok, exp_b);
            else passed++;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Called at #1 after an edge while idle; returns at #1 after the accept edge.
  task automatic send(input logic [7:0] b, input bit push);
    transmit_byte = b;
    tran_data     = 1'b1;
    if (push) sb_q.push_back(b);
    @(posedge clock); #1;
    tran_data = 1'b0;
  endtask

  // Measures one frame on dut from cycle 1 until tx_busy drops (no comparisons here).
  task automatic run_frame(input logic [7:0] b, input int inject_at, input logic [7:0] inj,
                           input bit scramble, output int busy_cnt, output int done_cnt,
                           output int done_at, output int tx_err);
    int   k;
    int   idx;
    logic exp_tx;
    busy_cnt = 0; done_cnt = 0; done_at = -1; tx_err = 0; k = 1;
    while (tx_busy === 1'b1 && k <= 300) begin
      idx = (k - 1) / CPB;
      if (idx == 0) exp_tx = 1'b0;
      else if (idx <= 8) exp_tx = b[idx-1];
      else exp_tx = 1'b1;
      busy_cnt++;
      if (tx !== exp_tx) tx_err++;
      if (tx_done === 1'b1) begin
        done_cnt++;
        done_at = k;
      end
      tran_data = (k == inject_at);
      if (k == inject_at) transmit_byte = inj;
      if (scramble) transmit_byte = 8'($urandom);
      @(posedge clock); #1;
      k++;
    end
    tran_data = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; tran_data = 1'b0; tran_data2 = 1'b0;
    transmit_byte = 8'h00; transmit_byte2 = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({tx, tx_busy, tx_done, tx2, tx_busy2, tx_done2} !== 6'b100100)
      $display("FAIL reset_outputs: tx/busy/done=%b%b%b tx2/busy2/done2=%b%b%b, required 100 100",
               tx, tx_busy, tx_done, tx2, tx_busy2, tx_done2);
    else passed++;
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({tx, tx_busy, tx_done} !== 3'b100)
      $display("FAIL idle_after_reset: tx/busy/done=%b%b%b, required 100", tx, tx_busy, tx_done);
    else passed++;
  endtask

  task automatic test_single();
    int bc, dc, da, te;
    send(8'hA5, 1);
    run_frame(8'hA5, -1, 8'h00, 0, bc, dc, da, te);
    checks++;
    if (bc != 100) $display("FAIL a5_busy_len: got %0d cycles, required 100", bc); else passed++;
    checks++;
    if (dc != 1 || da != 100)
      $display("FAIL a5_done: %0d pulses at cycle %0d, required 1 at 100", dc, da);
    else passed++;
    checks++;
    if (te != 0) $display("FAIL a5_tx_pattern: %0d wrong cycles, required 0", te); else passed++;
  endtask

  task automatic test_back_to_back();
    int bc, dc, da, te;
    send(8'h00, 1);
    run_frame(8'h00, -1, 8'h00, 0, bc, dc, da, te);
    checks++;
    if (bc != 100 || te != 0)
      $display("FAIL b2b_first: busy=%0d tx_err=%0d, required 100 and 0", bc, te);
    else passed++;
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0)
      $display("FAIL b2b_gap_idle: tx=%b busy=%b, required 1 0", tx, tx_busy);
    else passed++;
    send(8'hFF, 1);
    checks++;
    if (tx !== 1'b0 || tx_busy !== 1'b1)
      $display("FAIL b2b_second_start: tx=%b busy=%b, required 0 1", tx, tx_busy);
    else passed++;
    run_frame(8'hFF, -1, 8'h00, 0, bc, dc, da, te);
    checks++;
    if (bc != 100 || te != 0)
      $display("FAIL b2b_second: busy=%0d tx_err=%0d, required 100 and 0", bc, te);
    else passed++;
  endtask

  task automatic test_ignore_busy();
    int bc, dc, da, te, bad;
    send(8'h81, 1);
    run_frame(8'h81, 40, 8'h3C, 0, bc, dc, da, te);
    checks++;
    if (bc != 100 || te != 0)
      $display("FAIL ignore_frame: busy=%0d tx_err=%0d, required 100 and 0", bc, te);
    else passed++;
    bad = 0;
    repeat (20) begin
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
      @(posedge clock); #1;
    end
    checks++;
    if (bad != 0) $display("FAIL ignore_idle: %0d non-idle cycles, required 0", bad); else passed++;
  endtask

  task automatic test_byte_change();
    int bc, dc, da, te;
    send(8'h5A, 1);
    run_frame(8'h5A, -1, 8'h00, 1, bc, dc, da, te);
    checks++;
    if (bc != 100 || te != 0)
      $display("FAIL byte_change: busy=%0d tx_err=%0d, required 100 and 0", bc, te);
    else passed++;
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid_frame();
    int bc, dc, da, te, bad;
    send(8'hE7, 0);
    repeat (36) begin
      @(posedge clock); #1;
    end
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0)
      $display("FAIL async_reset: tx=%b busy=%b done=%b, required 1 0 0", tx, tx_busy, tx_done);
    else passed++;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock); #1;
    bad = 0;
    repeat (30) begin
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
      @(posedge clock); #1;
    end
    checks++;
    if (bad != 0) $display("FAIL post_reset_idle: %0d non-idle cycles, required 0", bad);
    else passed++;
    send(8'hC3, 1);
    run_frame(8'hC3, -1, 8'h00, 0, bc, dc, da, te);
    checks++;
    if (bc != 100 || te != 0 || dc != 1)
      $display("FAIL post_reset_frame: busy=%0d tx_err=%0d done=%0d, required 100 0 1", bc, te, dc);
    else passed++;
  endtask

  task automatic test_two_stop_bits();
    logic [7:0] b;
    int   k, idx, bc, dc, da, te, stop_hi;
    logic exp_tx;
    b = 8'h01;
    transmit_byte2 = b;
    tran_data2     = 1'b1;
    @(posedge clock); #1;
    tran_data2 = 1'b0;
    bc = 0; dc = 0; da = -1; te = 0; stop_hi = 0; k = 1;
    while (tx_busy2 === 1'b1 && k <= 300) begin
      idx = (k - 1) / CPB;
      if (idx == 0) exp_tx = 1'b0;
      else if (idx <= 8) exp_tx = b[idx-1];
      else exp_tx = 1'b1;
      bc++;
      if (tx2 !== exp_tx) te++;
      if (idx >= 9 && tx2 === 1'b1) stop_hi++;
      if (tx_done2 === 1'b1) begin
        dc++;
        da = k;
      end
      @(posedge clock); #1;
      k++;
    end
    checks++;
    if (bc != 110) $display("FAIL stop2_busy_len: got %0d, required 110", bc); else passed++;
    checks++;
    if (dc != 1 || da != 110)
      $display("FAIL stop2_done: %0d pulses at cycle %0d, required 1 at 110", dc, da);
    else passed++;
    checks++;
    if (te != 0 || stop_hi != 20)
      $display("FAIL stop2_pattern: tx_err=%0d stop_high=%0d, required 0 and 20", te, stop_hi);
    else passed++;
    checks++;
    if (tx2 !== 1'b1) $display("FAIL stop2_idle: tx2=%b, required 1", tx2); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_busy();
    test_byte_change();
    test_reset_mid_frame();
    test_two_stop_bits();
    repeat (5) @(posedge clock);
    #1;
    checks++;
    if (sb_q.size() != 0)
      $display("FAIL scoreboard_drain: %0d bytes never seen, required 0", sb_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
